rnd_sequence_game: RTL and testbench

Memory-game controller that sits directly downstream of the slow 4-bit LFSR generator. It consumes the generator's `rnd` nibble and captures a sequence of DEPTH fresh non-zero values. It then replays the sequence on a display bus, one value at a time, and checks a user-entered sequence of key nibbles against it. It reports pass/fail and keeps a running score of consecutive passed rounds.

---
 rtl/rnd_sequence_game_if.sv | 17 +
 rtl/rnd_sequence_game.sv | 109 ++++++++++
 tb/tb_rnd_sequence_game.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rnd_sequence_game_if.sv
// rnd_sequence_game_if: generator/key inputs and display/verdict outputs of the memory game.
interface rnd_sequence_game_if;
  logic [3:0] i_rnd;
  logic       i_start;
  logic       i_key_valid;
  logic [3:0] i_key;
  logic [3:0] o_show;
  logic       o_show_valid;
  logic       o_busy;
  logic       o_pass;
  logic       o_fail;
  logic [3:0] o_score;
  modport master (output i_rnd, i_start, i_key_valid, i_key,
                  input  o_show, o_show_valid, o_busy, o_pass, o_fail, o_score);
  modport slave  (input  i_rnd, i_start, i_key_valid, i_key,
                  output o_show, o_show_valid, o_busy, o_pass, o_fail, o_score);
endinterface

// File: rtl/rnd_sequence_game.sv
// rnd_sequence_game: captures DEPTH fresh LFSR nibbles, replays them, then checks keyed entry.
module rnd_sequence_game #(
  parameter int DEPTH       = 4,
  parameter int SHOW_CYCLES = 50_000_000,
  parameter int TIMEOUT     = 100_000_000
) (
  input logic clk,
  input logic rst_n,
  rnd_sequence_game_if.slave bus
);
  localparam int SW = SHOW_CYCLES > 1 ? $clog2(SHOW_CYCLES) : 1;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [2:0] LAST = 3'(DEPTH - 1);
  typedef enum logic [2:0] {IDLE, COLLECT, SHOW, ENTER, PASS, FAIL} state_t;
  state_t r_state, w_state;
  logic [3:0] r_rnd_q, r_score, w_score, r_show, w_show;
  logic [3:0] r_buf [8];
  logic [2:0] r_idx, w_idx;
  logic [SW-1:0] r_dwell, w_dwell;
  logic [TW-1:0] r_tmo, w_tmo;
  logic r_show_valid, r_busy, r_pass, r_fail, w_new, w_wr;
  always_comb begin
    w_new   = (bus.i_rnd != r_rnd_q) && (bus.i_rnd != 4'd0);
    w_state = r_state;
    w_idx   = r_idx;
    w_dwell = r_dwell;
    w_tmo   = r_tmo;
    w_score = r_score;
    w_wr    = 1'b0;
    case (r_state)
      IDLE: if (bus.i_start) begin
        w_state = COLLECT;
        w_idx   = 3'd0;
      end
      COLLECT: if (w_new) begin
        w_wr    = 1'b1;
        w_dwell = '0;
        w_idx   = r_idx == LAST ? 3'd0 : r_idx + 3'd1;
        w_state = r_idx == LAST ? SHOW : COLLECT;
      end
      SHOW: if (r_dwell == SW'(SHOW_CYCLES - 1)) begin
        w_dwell = '0;
        w_tmo   = '0;
        w_idx   = r_idx == LAST ? 3'd0 : r_idx + 3'd1;
        w_state = r_idx == LAST ? ENTER : SHOW;
      end else begin
        w_dwell = r_dwell + SW'(1);
      end
      // A key on the timeout terminal cycle takes priority over the timeout.
      ENTER: if (bus.i_key_valid) begin
        w_tmo = '0;
        if (bus.i_key != r_buf[r_idx]) begin
          w_state = FAIL;
        end else if (r_idx == LAST) begin
          w_state = PASS;
          w_score = r_score == 4'd15 ? 4'd15 : r_score + 4'd1;
        end else begin
          w_idx = r_idx + 3'd1;
        end
      end else if (r_tmo == TW'(TIMEOUT - 1)) begin
        w_state = FAIL;
      end else begin
        w_tmo = r_tmo + TW'(1);
      end
      PASS, FAIL: if (bus.i_start) begin
        w_state = COLLECT;
        w_idx   = 3'd0;
        w_score = r_state == FAIL ? 4'd0 : r_score;
      end
      default: w_state = IDLE;
    endcase
    // With DEPTH=1 the entry shown first is the one being written on this edge.
    w_show = (w_wr && r_idx == w_idx) ? bus.i_rnd : r_buf[w_idx];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state      <= IDLE;
      r_idx        <= 3'd0;
      r_rnd_q      <= 4'd0;
      r_dwell      <= '0;
      r_tmo        <= '0;
      r_score      <= 4'd0;
      r_show       <= 4'd0;
      r_show_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_idx        <= w_idx;
      r_rnd_q      <= bus.i_rnd;
      r_dwell      <= w_dwell;
      r_tmo        <= w_tmo;
      r_score      <= w_score;
      r_show       <= w_state == SHOW ? w_show : 4'd0;
      r_show_valid <= w_state == SHOW;
      r_busy       <= w_state == COLLECT || w_state == SHOW || w_state == ENTER;
      r_pass       <= w_state == PASS;
      r_fail       <= w_state == FAIL;
    end
  always_ff @(posedge clk)
    if (w_wr) r_buf[r_idx] <= bus.i_rnd;
  assign bus.o_show       = r_show;
  assign bus.o_show_valid = r_show_valid;
  assign bus.o_busy       = r_busy;
  assign bus.o_pass       = r_pass;
  assign bus.o_fail       = r_fail;
  assign bus.o_score      = r_score;
endmodule

// File: tb/tb_rnd_sequence_game.sv
// tb_rnd_sequence_game: directed and randomized rounds against a sequence-level game model.
module tb_rnd_sequence_game;
  localparam int D = 3, SC = 4, TO = 10;
  typedef enum {P_IDLE, P_BUSY, P_PASS, P_FAIL} phase_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0, n_fail = 0;
  logic [3:0] m_prev = 4'd0;
  logic [3:0] m_seq[$];
  bit m_collect = 1'b0;
  int m_score = 0, m_kidx = 0;
  phase_t m_phase = P_IDLE;
  always #5 clk = ~clk;
  rnd_sequence_game_if bus();
  rnd_sequence_game #(.DEPTH(D), .SHOW_CYCLES(SC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  task automatic chk_state(input string tag, input logic [3:0] show, input logic sv);
    n_tests++;
    assert (bus.o_show === show) else begin n_fail++; $error("FAIL %s show observed=%0d expected=%0d", tag, bus.o_show, show); end
    n_tests++;
    assert (bus.o_show_valid === sv) else begin n_fail++; $error("FAIL %s show_valid observed=%0b expected=%0b", tag, bus.o_show_valid, sv); end
    n_tests++;
    assert (bus.o_busy === (m_phase == P_BUSY)) else begin n_fail++; $error("FAIL %s busy observed=%0b expected=%0b", tag, bus.o_busy, m_phase == P_BUSY); end
    n_tests++;
    assert (bus.o_pass === (m_phase == P_PASS)) else begin n_fail++; $error("FAIL %s pass observed=%0b expected=%0b", tag, bus.o_pass, m_phase == P_PASS); end
    n_tests++;
    assert (bus.o_fail === (m_phase == P_FAIL)) else begin n_fail++; $error("FAIL %s fail observed=%0b expected=%0b", tag, bus.o_fail, m_phase == P_FAIL); end
    n_tests++;
    assert (bus.o_score === 4'(m_score)) else begin n_fail++; $error("FAIL %s score observed=%0d expected=%0d", tag, bus.o_score, m_score); end
  endtask
  // Model: a value is captured when it differs from the previous cycle's value and is non-zero.
  task automatic tick();
    if (rst_n && m_collect && bus.i_rnd != m_prev && bus.i_rnd != 4'd0) begin
      m_seq.push_back(bus.i_rnd);
      if (m_seq.size() == D) m_collect = 1'b0;
    end
    m_prev = rst_n ? bus.i_rnd : 4'd0;
    @(posedge clk);
    #1;
  endtask
  task automatic do_start();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    if (m_phase != P_BUSY) begin
      if (m_phase == P_FAIL) m_score = 0;
      m_phase = P_BUSY;
      m_collect = 1'b1;
      m_seq.delete();
      m_kidx = 0;
    end
    chk_state("start", 4'd0, 1'b0);
  endtask
  task automatic feed(input logic [3:0] v, input logic st);
    bus.i_rnd = v;
    bus.i_start = st;
    tick();
    bus.i_start = 1'b0;
    if (m_collect) chk_state("collect", 4'd0, 1'b0);
  endtask
  task automatic collect_rand();
    int budget = 300;
    while (m_collect && budget > 0) begin
      feed(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      budget--;
    end
    n_tests++;
    assert (!m_collect) else begin n_fail++; $error("FAIL collect_budget captured=%0d required=%0d", m_seq.size(), D); end
  endtask
  task automatic show_phase(input bit poke);
    for (int k = 0; k < D * SC; k++) begin
      chk_state("show", m_seq[k / SC], 1'b1);
      bus.i_key_valid = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.i_key = 4'($urandom_range(0, 15));
      tick();
    end
    bus.i_key_valid = 1'b0;
    chk_state("enter", 4'd0, 1'b0);
  endtask
  task automatic key(input logic [3:0] v, input int gap);
    repeat (gap) begin
      tick();
      chk_state("gap", 4'd0, 1'b0);
    end
    bus.i_key_valid = 1'b1;
    bus.i_key = v;
    tick();
    bus.i_key_valid = 1'b0;
    if (v != m_seq[m_kidx]) m_phase = P_FAIL;
    else if (m_kidx == D - 1) begin
      m_phase = P_PASS;
      m_score = m_score == 15 ? 15 : m_score + 1;
    end else m_kidx++;
    chk_state("key", 4'd0, 1'b0);
  endtask
  initial begin
    bus.i_rnd = 4'd0;
    bus.i_start = 1'b0;
    bus.i_key_valid = 1'b0;
    bus.i_key = 4'd0;
    repeat (2) tick();
    chk_state("reset", 4'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_state("idle", 4'd0, 1'b0);
    // Capture filter with a start pulse mid-collect and key pulses during show.
    do_start();
    feed(4'd0, 1'b0);
    feed(4'd13, 1'b0);
    feed(4'd13, 1'b1);
    feed(4'd0, 1'b0);
    feed(4'd11, 1'b0);
    feed(4'd7, 1'b0);
    bus.i_rnd = 4'd14;
    show_phase(1'b1);
    key(4'd13, 2);
    key(4'd11, 5);
    key(4'd7, 9);
    // Fifteen more passing rounds saturate the score.
    for (int r = 0; r < 15; r++) begin
      do_start();
      collect_rand();
      show_phase(1'($urandom_range(0, 1)));
      for (int i = 0; i < D; i++) key(m_seq[i], $urandom_range(0, 8));
    end
    // Mismatch on the second key.
    do_start();
    feed(4'd0, 1'b0);
    feed(4'd13, 1'b0);
    feed(4'd11, 1'b0);
    feed(4'd7, 1'b0);
    show_phase(1'b0);
    key(4'd13, 1);
    key(4'd9, 3);
    do_start();
    // Timeout with no keys.
    collect_rand();
    show_phase(1'b0);
    repeat (TO - 1) begin
      tick();
      chk_state("tmo_wait", 4'd0, 1'b0);
    end
    tick();
    m_phase = P_FAIL;
    chk_state("timeout", 4'd0, 1'b0);
    // Key on the timeout terminal-count cycle is accepted.
    do_start();
    collect_rand();
    show_phase(1'b0);
    key(m_seq[0], TO - 1);
    key(m_seq[1], 0);
    key(m_seq[2], 3);
    // Asynchronous reset in the middle of SHOW.
    do_start();
    collect_rand();
    repeat (5) begin
      tick();
      chk_state("pre_reset", bus.o_show_valid ? bus.o_show : 4'd0, bus.o_show_valid);
    end
    rst_n = 1'b0;
    #1;
    m_phase = P_IDLE;
    m_score = 0;
    m_collect = 1'b0;
    chk_state("async_reset", 4'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      feed(4'($urandom_range(1, 15)), 1'b0);
      chk_state("post_reset", 4'd0, 1'b0);
    end
    do_start();
    collect_rand();
    show_phase(1'b0);
    for (int i = 0; i < D; i++) key(m_seq[i], 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
